// File: rtl/iob2axil_bridge_pkg.sv
// iob2axil_bridge_pkg: AXI-Lite constants and bridge FSM state encoding
package iob2axil_bridge_pkg;
    localparam int AXI_PROT_W = 3;
    localparam int AXI_RESP_W = 2;
    localparam logic [AXI_RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [AXI_RESP_W-1:0] RESP_EXOKAY = 2'b01;
    localparam logic [AXI_RESP_W-1:0] RESP_SLVERR = 2'b10;
    localparam logic [AXI_RESP_W-1:0] RESP_DECERR = 2'b11;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        DONE    = 3'd5
    } state_e;
endpackage

// File: rtl/iob2axil_wdog.sv
// iob2axil_wdog: saturating busy-cycle counter that flags a dead slave
module iob2axil_wdog #(
    parameter int TIMEOUT = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expired
);
    if (TIMEOUT > 0) begin : g_on
        localparam int W = $clog2(TIMEOUT + 1);
        logic [W-1:0] cnt_q, cnt_d;
        always_comb cnt_d = clr ? '0 : (en && cnt_q != W'(TIMEOUT)) ? cnt_q + W'(1) : cnt_q;
        always_ff @(posedge clk) begin
            if (!rst) cnt_q <= '0;
            else      cnt_q <= cnt_d;
        end
        // fires one cycle early so the abort lands in DONE exactly TIMEOUT+1 cycles after IDLE
        assign expired = en && cnt_q == W'(TIMEOUT - 1);
    end else begin : g_off
        logic unused;
        assign unused  = ^{clk, rst, en, clr};
        assign expired = 1'b0;
    end
endmodule

// File: rtl/iob2axil_bridge.sv
// iob2axil_bridge: native single-beat request to AXI4-Lite master transaction
module iob2axil_bridge
    import iob2axil_bridge_pkg::*;
#(
    parameter int          ADDR_W  = 32,
    parameter int          DATA_W  = 32,
    parameter logic [2:0]  PROT    = 3'd2,
    parameter int          TIMEOUT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    output logic [DATA_W-1:0]     rdata,
    output logic                  ready,
    output logic                  err,
    output logic [ADDR_W-1:0]     axil_awaddr,
    output logic [AXI_PROT_W-1:0] axil_awprot,
    output logic                  axil_awvalid,
    input  logic                  axil_awready,
    output logic [DATA_W-1:0]     axil_wdata,
    output logic [DATA_W/8-1:0]   axil_wstrb,
    output logic                  axil_wvalid,
    input  logic                  axil_wready,
    input  logic [AXI_RESP_W-1:0] axil_bresp,
    input  logic                  axil_bvalid,
    output logic                  axil_bready,
    output logic [ADDR_W-1:0]     axil_araddr,
    output logic [AXI_PROT_W-1:0] axil_arprot,
    output logic                  axil_arvalid,
    input  logic                  axil_arready,
    input  logic [DATA_W-1:0]     axil_rdata,
    input  logic [AXI_RESP_W-1:0] axil_rresp,
    input  logic                  axil_rvalid,
    output logic                  axil_rready
);
    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic                aw_done_q, aw_done_d, w_done_q, w_done_d, err_q, err_d;
    logic                busy, expired;

    assign busy = state_q inside {WR, WR_RESP, RD_ADDR, RD_DATA};

    iob2axil_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .en      (busy),
        .clr     (!busy),
        .expired (expired)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        if (expired) begin
            state_d = DONE;
            err_d   = 1'b1;
            rdata_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (valid) begin
                        addr_d  = addr;
                        wdata_d = wdata;
                        wstrb_d = wstrb;
                        rdata_d = '0;
                        err_d   = 1'b0;
                        state_d = |wstrb ? WR : RD_ADDR;
                    end
                end
                WR: begin
                    aw_done_d = aw_done_q | (axil_awvalid & axil_awready);
                    w_done_d  = w_done_q | (axil_wvalid & axil_wready);
                    if (aw_done_d && w_done_d) state_d = WR_RESP;
                end
                WR_RESP: begin
                    if (axil_bvalid) begin
                        err_d   = axil_bresp != RESP_OKAY;
                        state_d = DONE;
                    end
                end
                RD_ADDR: state_d = axil_arready ? RD_DATA : RD_ADDR;
                RD_DATA: begin
                    if (axil_rvalid) begin
                        rdata_d = axil_rdata;
                        err_d   = axil_rresp != RESP_OKAY;
                        state_d = DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    assign ready        = state_q == DONE;
    assign rdata        = rdata_q;
    assign err          = err_q;
    assign axil_awaddr  = addr_q;
    assign axil_araddr  = addr_q;
    assign axil_awprot  = PROT;
    assign axil_arprot  = PROT;
    assign axil_wdata   = wdata_q;
    assign axil_wstrb   = wstrb_q;
    assign axil_awvalid = state_q == WR && !aw_done_q;
    assign axil_wvalid  = state_q == WR && !w_done_q;
    assign axil_bready  = state_q == WR_RESP;
    assign axil_arvalid = state_q == RD_ADDR;
    assign axil_rready  = state_q == RD_DATA;
endmodule

// File: doc/iob2axil_bridge.md
# iob2axil_bridge

Native-to-AXI4-Lite master bridge, next generation of the single-beat native/AXI-Lite adapter. It converts one native request into one AXI4-Lite transaction through an explicit FSM with registered request capture, independent AW/W acceptance, response-error reporting and an optional watchdog timeout. It sits between a native-bus master (CPU or DMA) and an AXI4-Lite interconnect.

## Interface
Parameters:
- `ADDR_W`, 32: address width, native and AXI.
- `DATA_W`, 32: data width; must be 32 or 64.
- `PROT`, 3'd2: constant driven on `axil_awprot` and `axil_arprot`.
- `TIMEOUT`, 0: watchdog limit in cycles; 0 disables the watchdog.

Ports:
- `clk` in 1: clock. One clock domain.
- `rst` in 1: reset, synchronous, active-low.
- `valid` in 1: native request. Held by the master until `ready`.
- `addr` in ADDR_W: native address.
- `wdata` in DATA_W: native write data.
- `wstrb` in DATA_W/8: byte strobes. Non-zero means write; zero means read.
- `rdata` out DATA_W: read data. Valid only while `ready`=1.
- `ready` out 1: one-cycle completion pulse.
- `err` out 1: error flag. Valid only while `ready`=1.
- AXI-Lite write address: `axil_awaddr` out ADDR_W, `axil_awprot` out 3, `axil_awvalid` out 1, `axil_awready` in 1.
- AXI-Lite write data: `axil_wdata` out DATA_W, `axil_wstrb` out DATA_W/8, `axil_wvalid` out 1, `axil_wready` in 1.
- AXI-Lite write response: `axil_bresp` in 2, `axil_bvalid` in 1, `axil_bready` out 1.
- AXI-Lite read address: `axil_araddr` out ADDR_W, `axil_arprot` out 3, `axil_arvalid` out 1, `axil_arready` in 1.
- AXI-Lite read data: `axil_rdata` in DATA_W, `axil_rresp` in 2, `axil_rvalid` in 1, `axil_rready` out 1.

## Operation
- FSM states: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, DONE. All outputs are Moore-decoded from state and registers.
- **IDLE**
  - On `valid`=1, capture `addr`, `wdata` and `wstrb` into registers.
  - If `|wstrb`, go to WR; otherwise go to RD_ADDR.
- **WR**
  - `axil_awvalid` = ~aw_done; `axil_wvalid` = ~w_done.
  - aw_done sets on the AW handshake; w_done sets on the W handshake. The two channels are accepted independently, in either order or in the same cycle.
  - Go to WR_RESP once both flags are set, counting a handshake in the current cycle.
- **WR_RESP**
  - `axil_bready`=1.
  - On `axil_bvalid`, latch `err` = (`axil_bresp` != OKAY) and go to DONE.
- **RD_ADDR**
  - `axil_arvalid`=1.
  - On `axil_arready`, go to RD_DATA.
- **RD_DATA**
  - `axil_rready`=1.
  - On `axil_rvalid`, latch `rdata` = `axil_rdata` and `err` = (`axil_rresp` != OKAY), then go to DONE.
- **DONE**
  - `ready`=1 for exactly one cycle, then return to IDLE.
  - `valid` is ignored in DONE, so a held `valid` is never re-accepted.
- **AXI output sourcing**
  - `axil_awaddr`/`axil_araddr` come from the captured address register.
  - `axil_wdata`/`axil_wstrb` come from the captured data and strobe registers.
  - These outputs are stable while the corresponding valid is high.
- **Watchdog**
  - Active only when `TIMEOUT`>0.
  - The counter clears in IDLE and increments in WR, WR_RESP, RD_ADDR and RD_DATA.
  - When it reaches `TIMEOUT`, drop all AXI valid/ready outputs and go to DONE with `err`=1 and `rdata`=0.
  - This is a dead-slave abort; a late response after it is ignored.
- **Read data on failure**: a read with non-OKAY `rresp` still returns the captured `axil_rdata`.

## Timing
- **Reset values**: state IDLE; `ready`, `err`, all AXI valid/ready outputs = 0; `rdata` = 0; addr/data/strb registers = 0.
- **Reset mid-transaction**: state returns to IDLE and all AXI outputs deassert in the cycle after `rst` is sampled low. No response is generated.
- **Write latency** with a zero-wait slave (B returned one cycle after AW/W):
  - cycle 0: `valid` sampled.
  - cycle 1: AW and W both handshake.
  - cycle 2: `axil_bvalid`/`axil_bready` handshake.
  - cycle 3: `ready`.
- **Read latency** with a zero-wait slave: `arvalid` in cycle 1, R handshake in cycle 2, `ready` with `rdata` in cycle 3.
- **Back-to-back throughput**: the earliest new acceptance is the cycle after DONE, giving 4 cycles per transaction minimum.
- **Watchdog abort latency**: `ready` asserts `TIMEOUT`+1 cycles after leaving IDLE.
- **Counter width**: $clog2(TIMEOUT+1). It saturates and does not wrap.

## Structure
- Shared header `axi.vh`: `AXI_PROT_W`=3, `AXI_RESP_W`=2, response codes OKAY=2'b00, EXOKAY, SLVERR, DECERR.
- Local header `iob2axil_bridge.vh`: FSM state encodings, 3-bit binary.
- One sub-module, `iob2axil_wdog`:
  - Parametrised by `TIMEOUT`; inputs `en` and `clr`; output `expired`.
  - Generates no logic when `TIMEOUT`=0.

## Test plan
1. Write `addr`=0x10, `wdata`=0xDEADBEEF, `wstrb`=0xF, zero-wait slave -> AW/W show 0x10/0xDEADBEEF/0xF; `ready` asserts cycle 3 with `err`=0; `valid` held through DONE is not re-accepted.
2. Read 0x20, slave returns 0x12345678 OKAY after 5 wait cycles on `arready` and 3 on `rvalid` -> `ready` with `rdata`=0x12345678, `err`=0, exactly one AR handshake.
3. Write with `wready` 4 cycles ahead of `awready`, then repeat with `awready` first -> exactly one AW and one W handshake in each case; `bready` asserts only after both.
4. Read with `rresp`=SLVERR, then write with `bresp`=DECERR -> `err`=1 on each `ready`; `rdata` equals the slave data for the read.
5. `TIMEOUT`=16, slave never asserts `arready` -> `arvalid` drops and `ready`=1, `err`=1, `rdata`=0 in cycle 17; the next request proceeds normally.
6. `rst` low during WR_RESP -> next cycle all AXI outputs are 0, state IDLE, no `ready`; the following read completes correctly.
